// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: RX FIFO sequencer, RBR prefetch, RDA/CTO interrupt sources and overrun flag
module uart_rx_fifo_ctrl #(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       char_tick,
    input  logic       fcr_wr,
    input  logic [7:0] fcr_data,
    input  logic       rbr_rd,
    input  logic       lsr_rd,
    output logic [7:0] rbr_data,
    output logic       rbr_valid,
    output logic       overrun_err,
    output logic       irq_rda,
    output logic       irq_cto,
    output logic       fifo_rst,
    output logic       fifo_en,
    output logic       fifo_push,
    output logic       fifo_pop,
    output logic [7:0] fifo_din,
    output logic [3:0] fifo_thres,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    input  logic       fifo_full,
    input  logic       fifo_thres_tri
);
    localparam int CW = $clog2(TIMEOUT_CHARS + 1);
    typedef enum logic [1:0] {EMPTY, CAPT, FULL} state_t;
    state_t state, state_nx;
    logic en, clr, clr_pulse, block, unused_fcr;
    logic [1:0] lvl;
    logic [CW-1:0] cnt;
    assign unused_fcr = ^fcr_data[5:2];
    assign clr = fcr_wr & (fcr_data[1] | (fcr_data[0] != en));
    assign block = en ? fifo_full : (~fifo_empty | rbr_valid);
    assign fifo_push = rx_valid & ~block & ~clr_pulse;
    assign fifo_rst = rst | clr_pulse;
    assign fifo_en = 1'b1;
    assign fifo_din = rx_data;
    assign fifo_thres = lvl == 2'd0 ? 4'd0 : lvl == 2'd1 ? 4'(DEPTH / 4 - 1) :
                        lvl == 2'd2 ? 4'(DEPTH / 2 - 1) : 4'(DEPTH - 3);
    assign irq_rda = rbr_valid & (~en | lvl == 2'd0 | fifo_thres_tri);
    assign irq_cto = en & rbr_valid & (cnt == CW'(TIMEOUT_CHARS));
    // FCR fields and the one-cycle FIFO clear pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            en <= 1'b0;
            lvl <= 2'd0;
            clr_pulse <= 1'b0;
        end else begin
            clr_pulse <= clr;
            if (fcr_wr) begin
                en <= fcr_data[0];
                lvl <= fcr_data[7:6];
            end
        end
    end
    // holding-register state; a FIFO clear forces it back to EMPTY
    always_ff @(posedge clk) begin
        if (rst | clr) state <= EMPTY;
        else state <= state_nx;
    end
    // prefetch sequencing: pop when RBR is free, capture the cycle after
    always_comb begin
        state_nx = state == CAPT ? FULL : (state == FULL & ~rbr_rd) ? FULL : fifo_pop ? CAPT : EMPTY;
    end
    // RBR status and pop strobe, never popping an empty or clearing FIFO
    always_comb begin
        rbr_valid = state == FULL;
        fifo_pop = ~fifo_empty & ~clr & ~clr_pulse & (state == EMPTY | (state == FULL & rbr_rd));
    end
    // capture the FIFO head into RBR
    always_ff @(posedge clk) begin
        if (rst) rbr_data <= 8'd0;
        else if (state == CAPT) rbr_data <= fifo_dout;
    end
    // sticky overrun: a dropped byte wins over the LSR read clear
    always_ff @(posedge clk) begin
        if (rst) overrun_err <= 1'b0;
        else if (rx_valid & block) overrun_err <= 1'b1;
        else if (lsr_rd) overrun_err <= 1'b0;
    end
    // character-timeout counter, saturating
    always_ff @(posedge clk) begin
        if (rst | clr | fifo_push | rbr_rd | ~rbr_valid) cnt <= '0;
        else if (char_tick & cnt != CW'(TIMEOUT_CHARS)) cnt <= cnt + 1'b1;
    end
endmodule
